palette_access_ctrl: RTL and testbench

PALETTE_ACCESS_CTRL -- requirements
Module: palette_access_ctrl

---
 rtl/pal_ctrl_pkg.sv | 22 ++
 rtl/pal_wr_fifo.sv | 55 +++++
 rtl/palette_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_palette_access_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_ctrl_pkg.sv
// Shared definitions for the palette access controller: the FSM state
// encoding, the posted-write entry layout and the CPU address field positions.
package pal_ctrl_pkg;

   localparam int ADDR_W  = 11;               // word address [11:1]
   localparam int DATA_W  = 16;
   localparam int ENTRY_W = ADDR_W + DATA_W;  // {address, data} per posted write

   // CPU address fields (bit positions within the [11:1] word address)
   localparam int RAM_SEL_HI = 11;
   localparam int RAM_SEL_LO = 10;
   localparam int IDX_HI     = 8;
   localparam int IDX_LO     = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RECOVER
   } pal_state_t;

endpackage

// File: rtl/pal_wr_fifo.sv
// Posted-write buffer: synchronous FIFO with a combinational head. A push and
// a pop in the same cycle are both taken and leave the occupancy unchanged.
module pal_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
      end
   end

   // Entry storage; contents are don't-care while the FIFO is empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/palette_access_ctrl.sv
// Arbitrates CPU access to the palette RAM against video use. Writes are
// posted into a small FIFO; a single read may be outstanding and is only
// serviced once the FIFO has drained, so it returns post-write data. Accesses
// wait for BLANK, or are forced after TIMEOUT clocks of waiting.
//
// CPU handshake: CPU_REQ is a request valid, CPU_BUSY is its inverted ready.
// A request is taken in any cycle where CPU_REQ=1 and CPU_BUSY=0; one taken
// while busy is dropped. CPU_READY is a one-cycle completion pulse: the cycle
// after an accepted write, or the cycle CPU_DOUT carries read data.
module palette_access_ctrl
   import pal_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int ACCESS_CYCLES = 2,
   parameter int TIMEOUT       = 1024
) (
   input  logic        CLK_32M,
   input  logic        RESET,
   input  logic        CPU_REQ,
   input  logic        CPU_WE,
   input  logic [11:1] CPU_A,
   input  logic [15:0] CPU_DIN,
   output logic [15:0] CPU_DOUT,
   output logic        CPU_READY,
   output logic        CPU_BUSY,
   input  logic        BLANK,
   output logic        PAL_G,
   output logic        PAL_MWR,
   output logic        PAL_MRD,
   output logic [11:1] PAL_A,
   output logic [15:0] PAL_DIN,
   input  logic [15:0] PAL_DOUT,
   output logic [15:0] FORCE_CNT,
   output pal_state_t  fsm_state
);

   localparam int TW = $clog2(TIMEOUT + 1);

   pal_state_t         state;
   logic [TW-1:0]      timer;
   logic [2:0]         acc_cnt;
   logic               acc_last;
   logic               acc_is_wr;
   logic               rd_pend;
   logic [11:1]        rd_addr;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic               rd_accept;
   logic [ENTRY_W-1:0] fifo_head;

   assign CPU_BUSY  = fifo_full || rd_pend;
   assign fifo_push = CPU_REQ && CPU_WE && !CPU_BUSY;
   assign rd_accept = CPU_REQ && !CPU_WE && !CPU_BUSY;
   assign acc_last  = (acc_cnt == 3'(ACCESS_CYCLES - 1));
   assign fifo_pop  = (state == ST_ACCESS) && acc_last && acc_is_wr;
   assign fsm_state = state;

   pal_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_wr_fifo (
      .clk   (CLK_32M),
      .rst   (RESET),
      .push  (fifo_push),
      .din   ({CPU_A, CPU_DIN}),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Access sequencer: wait for blanking (or time out), drive the palette, recover
   always_ff @(posedge CLK_32M) begin
      if (RESET) begin
         state     <= ST_IDLE;
         timer     <= '0;
         acc_cnt   <= '0;
         acc_is_wr <= 1'b0;
         rd_pend   <= 1'b0;
         rd_addr   <= '0;
         CPU_READY <= 1'b0;
         CPU_DOUT  <= '0;
         PAL_G     <= 1'b0;
         PAL_MWR   <= 1'b0;
         PAL_MRD   <= 1'b0;
         PAL_A     <= '0;
         PAL_DIN   <= '0;
         FORCE_CNT <= '0;
      end else begin
         // write acknowledge; a read completion below cannot coincide since reads hold BUSY
         CPU_READY <= fifo_push;
         if (rd_accept) begin
            rd_pend <= 1'b1;
            rd_addr <= CPU_A;
         end
         case (state)
            ST_IDLE: begin
               if (!fifo_empty || rd_pend) begin
                  state <= ST_WAIT;
                  timer <= '0;
               end
            end
            ST_WAIT: begin
               if (BLANK || timer == TW'(TIMEOUT - 1)) begin
                  state   <= ST_ACCESS;
                  acc_cnt <= '0;
                  PAL_G   <= 1'b1;
                  if (!BLANK && FORCE_CNT != 16'hFFFF) FORCE_CNT <= FORCE_CNT + 16'd1;
                  // buffered writes always go ahead of the pending read
                  if (!fifo_empty) begin
                     acc_is_wr <= 1'b1;
                     PAL_MWR   <= 1'b1;
                     PAL_A     <= fifo_head[ENTRY_W-1:DATA_W];
                     PAL_DIN   <= fifo_head[DATA_W-1:0];
                  end else begin
                     acc_is_wr <= 1'b0;
                     PAL_MRD   <= 1'b1;
                     PAL_A     <= rd_addr;
                     PAL_DIN   <= '0;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            ST_ACCESS: begin
               // BLANK is ignored here: a started access always runs to completion
               if (acc_last) begin
                  state   <= ST_RECOVER;
                  PAL_G   <= 1'b0;
                  PAL_MWR <= 1'b0;
                  PAL_MRD <= 1'b0;
                  PAL_A   <= '0;
                  PAL_DIN <= '0;
                  if (!acc_is_wr) begin
                     CPU_DOUT  <= PAL_DOUT;
                     CPU_READY <= 1'b1;
                     rd_pend   <= 1'b0;
                  end
               end else begin
                  acc_cnt <= acc_cnt + 3'd1;
               end
            end
            ST_RECOVER: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_palette_access_ctrl.sv
// Bench for palette_access_ctrl: directed scenarios followed by random CPU
// traffic and random blanking, checked against a transaction-level model
// (ordered list of palette accesses, reference memory, occupancy counts).
module tb_palette_access_ctrl;
   import pal_ctrl_pkg::*;

   localparam int DEPTH = 4;
   localparam int ACC   = 2;
   localparam int TMO   = 1024;

   // ---------------- clock / reset / DUT ----------------
   logic        CLK_32M = 1'b0;
   logic        RESET;
   logic        CPU_REQ;
   logic        CPU_WE;
   logic [11:1] CPU_A;
   logic [15:0] CPU_DIN;
   logic [15:0] CPU_DOUT;
   logic        CPU_READY;
   logic        CPU_BUSY;
   logic        BLANK;
   logic        PAL_G;
   logic        PAL_MWR;
   logic        PAL_MRD;
   logic [11:1] PAL_A;
   logic [15:0] PAL_DIN;
   logic [15:0] PAL_DOUT;
   logic [15:0] FORCE_CNT;
   pal_state_t  fsm_state;

   always #5 CLK_32M = ~CLK_32M;

   palette_access_ctrl #(
      .FIFO_DEPTH    (DEPTH),
      .ACCESS_CYCLES (ACC),
      .TIMEOUT       (TMO)
   ) dut (
      .CLK_32M   (CLK_32M),
      .RESET     (RESET),
      .CPU_REQ   (CPU_REQ),
      .CPU_WE    (CPU_WE),
      .CPU_A     (CPU_A),
      .CPU_DIN   (CPU_DIN),
      .CPU_DOUT  (CPU_DOUT),
      .CPU_READY (CPU_READY),
      .CPU_BUSY  (CPU_BUSY),
      .BLANK     (BLANK),
      .PAL_G     (PAL_G),
      .PAL_MWR   (PAL_MWR),
      .PAL_MRD   (PAL_MRD),
      .PAL_A     (PAL_A),
      .PAL_DIN   (PAL_DIN),
      .PAL_DOUT  (PAL_DOUT),
      .FORCE_CNT (FORCE_CNT),
      .fsm_state (fsm_state)
   );

   // palette chip: combinational read port, written while PAL_MWR is seen high
   logic [15:0] pal_mem [2048];
   assign PAL_DOUT = pal_mem[PAL_A];

   // ---------------- scoreboard / model ----------------
   // entry: {is_write, address[11:1], data}; for reads data is the expected return value
   logic [27:0] exp_q [$];
   logic [27:0] cur;
   logic [15:0] ref_mem [2048];
   int          wr_occ;
   bit          rd_pend_m;
   bit          busy_m;
   bit          exp_ready;
   bit          prev_g;
   logic        blank_prev;
   int          run_len;
   int          force_m;
   int          idle_cnt;
   int          cyc;
   int          last_ready_cyc;
   int          last_rise_cyc;
   int          rq;
   int          n_vec;
   int          n_err;
   logic [11:1] ra;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // one clock: book-keep accepted requests, advance, then compare everything observable
   task automatic cycle();
      bit acc_wr;
      bit acc_rd;
      acc_wr     = !RESET && CPU_REQ && CPU_WE && !busy_m;
      acc_rd     = !RESET && CPU_REQ && !CPU_WE && !busy_m;
      blank_prev = BLANK;
      @(posedge CLK_32M);
      #1;
      cyc++;
      if (PAL_MWR) pal_mem[PAL_A] = PAL_DIN;
      if (RESET) begin
         exp_q.delete();
         wr_occ    = 0;
         rd_pend_m = 0;
         busy_m    = 0;
         prev_g    = 0;
         force_m   = 0;
         idle_cnt  = 0;
         ref_mem   = pal_mem;
         check("rst_pal", 32'({PAL_G, PAL_MWR, PAL_MRD, PAL_A, PAL_DIN}), 32'd0);
         check("rst_cpu", 32'({CPU_READY, CPU_BUSY, CPU_DOUT}), 32'd0);
         check("rst_force", 32'(FORCE_CNT), 32'd0);
         check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
         return;
      end
      if (acc_wr) begin
         wr_occ++;
         exp_q.push_back({1'b1, CPU_A, CPU_DIN});
         ref_mem[CPU_A] = CPU_DIN;
      end
      if (acc_rd) begin
         rd_pend_m = 1;
         exp_q.push_back({1'b0, CPU_A, ref_mem[CPU_A]});
      end
      exp_ready = acc_wr;
      check("strobe_excl", 32'(PAL_MWR & PAL_MRD), 32'd0);
      if (PAL_G && !prev_g) begin
         last_rise_cyc = cyc;
         run_len = 1;
         if (!blank_prev && force_m < 16'hFFFF) force_m++;
         check("force_cnt", 32'(FORCE_CNT), force_m);
         if (exp_q.size() == 0) begin
            check("spurious_access", 32'(PAL_G), 32'd0);
            cur = {PAL_MWR, PAL_A, PAL_DIN};
         end else begin
            cur = exp_q.pop_front();
            check("acc_kind", 32'({PAL_MWR, PAL_MRD}), cur[27] ? 32'd2 : 32'd1);
            check("acc_addr", 32'(PAL_A), 32'(cur[26:16]));
            if (cur[27]) check("acc_data", 32'(PAL_DIN), 32'(cur[15:0]));
         end
      end else if (PAL_G) begin
         run_len++;
         check("acc_hold_kind", 32'({PAL_MWR, PAL_MRD}), cur[27] ? 32'd2 : 32'd1);
         check("acc_hold_addr", 32'(PAL_A), 32'(cur[26:16]));
         if (cur[27]) check("acc_hold_data", 32'(PAL_DIN), 32'(cur[15:0]));
      end else begin
         check("idle_pal", 32'({PAL_MWR, PAL_MRD, PAL_A, PAL_DIN}), 32'd0);
         if (prev_g) begin
            check("acc_len", run_len, ACC);
            if (cur[27]) begin
               if (wr_occ > 0) wr_occ--;
            end else begin
               exp_ready = 1;
               rd_pend_m = 0;
               check("rd_data", 32'(CPU_DOUT), 32'(cur[15:0]));
            end
         end
      end
      prev_g = PAL_G;
      busy_m = (wr_occ == DEPTH) || rd_pend_m;
      check("ready", 32'(CPU_READY), 32'(exp_ready));
      check("busy", 32'(CPU_BUSY), 32'(busy_m));
      if (CPU_READY) last_ready_cyc = cyc;
      if (exp_q.size() != 0 && !PAL_G) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt == TMO + 8) check("watchdog", idle_cnt, 0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic we, input logic [11:1] a, input logic [15:0] d);
      CPU_REQ = 1'b1;
      CPU_WE  = we;
      CPU_A   = a;
      CPU_DIN = d;
      cycle();
      CPU_REQ = 1'b0;
      CPU_WE  = 1'b0;
      CPU_A   = '0;
      CPU_DIN = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic drain(input int limit);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || rd_pend_m || wr_occ != 0 || PAL_G) && k < limit) begin
         cycle();
         k++;
      end
      if (k >= limit) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_access(input string tag);
      for (int k = 0; k < 12 && !PAL_G; k++) cycle();
      check(tag, 32'(PAL_G), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      wr_occ = 0; rd_pend_m = 0; busy_m = 0; exp_ready = 0; prev_g = 0;
      run_len = 0; force_m = 0; idle_cnt = 0; last_ready_cyc = 0; last_rise_cyc = 0;
      cur = '0; ra = '0; rq = 0;
      for (int i = 0; i < 2048; i++) begin
         pal_mem[i] = '0;
         ref_mem[i] = '0;
      end
      RESET = 1'b1; CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_A = '0; CPU_DIN = '0; BLANK = 1'b0;
      idle(2);
      RESET = 1'b0;
      idle(2);

      // single posted write during blanking
      BLANK = 1'b1;
      drive_req(1'b1, 11'h005, 16'h001F);
      drain(50);
      idle(2);

      // fill the FIFO while the palette is busy with video, then drain in order
      BLANK = 1'b0;
      for (int i = 0; i < 4; i++) drive_req(1'b1, 11'h100 + 11'(i), 16'hA000 + 16'(i));
      check("busy_when_full", 32'(CPU_BUSY), 32'd1);
      drive_req(1'b1, 11'h1FF, 16'hDEAD);
      idle(3);
      BLANK = 1'b1;
      drain(100);
      idle(2);
      drive_req(1'b0, 11'h1FF, 16'h0);
      drain(50);
      idle(2);

      // write then immediate read of the same address returns the new data
      drive_req(1'b1, 11'h210, 16'h000A);
      drive_req(1'b0, 11'h210, 16'h0);
      drain(50);
      check("rd_after_wr", 32'(CPU_DOUT), 32'h000A);
      idle(2);

      // minimum read latency
      rq = cyc;
      drive_req(1'b0, 11'h005, 16'h0);
      drain(50);
      check("rd_latency", last_ready_cyc - rq, 5);
      check("rd_latency_data", 32'(CPU_DOUT), 32'h001F);
      idle(2);

      // no blanking at all: the write is forced after the timeout
      BLANK = 1'b0;
      idle(2);
      rq = cyc;
      drive_req(1'b1, 11'h333, 16'h1234);
      drain(TMO + 50);
      check("force_latency", last_rise_cyc - rq, TMO + 2);
      check("force_cnt_one", 32'(FORCE_CNT), 32'd1);
      idle(2);

      // reset in the middle of a read access
      BLANK = 1'b1;
      drive_req(1'b0, 11'h210, 16'h0);
      wait_access("reach_rd_access");
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
      idle(10);

      // reset discards buffered writes
      BLANK = 1'b0;
      drive_req(1'b1, 11'h044, 16'h5555);
      drive_req(1'b1, 11'h045, 16'h6666);
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
      BLANK = 1'b1;
      idle(12);

      // blanking ends during an access: read and write still complete
      drive_req(1'b1, 11'h333, 16'h4321);
      wait_access("reach_wr_access");
      BLANK = 1'b0;
      drain(20);
      BLANK = 1'b1;
      idle(2);
      drive_req(1'b0, 11'h333, 16'h0);
      wait_access("reach_rd_access2");
      BLANK = 1'b0;
      drain(20);
      check("blank_fall_rd", 32'(CPU_DOUT), 32'h4321);
      idle(2);

      // random traffic with varying blanking patterns
      for (int blk = 0; blk < 40; blk++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int i = 0; i < 64; i++) begin
            case (mode)
               0:       BLANK = 1'($urandom_range(0, 1));
               1:       BLANK = ($urandom_range(0, 7) == 0);
               default: BLANK = ($urandom_range(0, 7) != 0);
            endcase
            if ($urandom_range(0, 2) == 0) begin
               ra = '0;
               ra[RAM_SEL_HI:RAM_SEL_LO] = 2'($urandom_range(0, 3));
               ra[9]                     = 1'($urandom_range(0, 1));
               ra[IDX_HI:IDX_LO]         = 8'($urandom_range(0, 7));
               drive_req(($urandom_range(0, 3) != 0), ra, 16'($urandom));
            end else begin
               cycle();
            end
         end
      end
      BLANK = 1'b1;
      drain(3000);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
